// File: rtl/seq_div32.sv
// seq_div32 - iterative signed divider, one quotient bit per clock.
//
// Restoring shift-subtract on operand magnitudes followed by sign correction.
// The quotient truncates toward zero and the remainder takes the sign of the
// dividend.
//
// Ports:
//   clock          rising-edge clock for all state
//   reset          synchronous, active-high
//   ctrl_div       start pulse; operands are valid in the same cycle
//   operandA       dividend, two's complement
//   operandB       divisor, two's complement
//   result         quotient, registered
//   remainder      remainder, registered
//   data_exception divide-by-zero or overflow; valid while data_resultRDY=1
//   data_resultRDY one-cycle pulse when result/remainder/exception are valid
//   busy           high while in RUN or FIN
//
// state | meaning
// IDLE  | waiting for ctrl_div
// RUN   | one shift/trial-subtract per clock, WIDTH iterations
// FIN   | sign correction and output write
// DONE  | data_resultRDY high for this one cycle
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] magb_q, magb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  // Magnitudes are unsigned WIDTH bits so that |MIN_NEG| = MIN_NEG is exact.
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;

  always_comb begin
    mag_a = operandA[WIDTH-1] ? -operandA : operandA;
    mag_b = operandB[WIDTH-1] ? -operandB : operandB;

    shifted   = {rem_q, quo_q[WIDTH-1]};
    no_borrow = (shifted >= {1'b0, magb_q});
    // When the subtraction is taken the difference is below |B|, so the
    // low WIDTH bits hold it exactly.
    diff      = shifted[WIDTH-1:0] - magb_q;

    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    magb_d      = magb_q;
    cnt_d       = cnt_q;
    sq_d        = sq_q;
    sr_d        = sr_q;
    dz_d        = dz_q;
    ovf_d       = ovf_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    exc_d       = exc_q;
    rdy_d       = 1'b0;

    if (ctrl_div) begin
      // A start in any state aborts whatever was in flight.
      magb_d = mag_b;
      sq_d   = operandA[WIDTH-1] ^ operandB[WIDTH-1];
      sr_d   = operandA[WIDTH-1];
      dz_d   = (operandB == '0);
      ovf_d  = (operandA == MIN_NEG) && (operandB == '1);
      cnt_d  = '0;
      if (operandB == '0) begin
        // Skip iteration: quotient 0, remainder |A| re-signed to A in FIN.
        rem_d   = mag_a;
        quo_d   = '0;
        state_d = FIN;
      end else begin
        rem_d   = '0;
        quo_d   = mag_a;
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (no_borrow) begin
            rem_d = diff;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIN;
        end
        FIN: begin
          result_d    = sq_q ? -quo_q : quo_q;
          remainder_d = sr_q ? -rem_q : rem_q;
          exc_d       = dz_q | ovf_q;
          rdy_d       = 1'b1;
          state_d     = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == RUN) || (state_d == FIN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      magb_q      <= '0;
      cnt_q       <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      result_q    <= '0;
      remainder_q <= '0;
      exc_q       <= 1'b0;
      rdy_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      magb_q      <= magb_d;
      cnt_q       <= cnt_d;
      sq_q        <= sq_d;
      sr_q        <= sr_d;
      dz_q        <= dz_d;
      ovf_q       <= ovf_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      exc_q       <= exc_d;
      rdy_q       <= rdy_d;
      busy_q      <= busy_d;
    end
  end

  assign result         = result_q;
  assign remainder      = remainder_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
